// File: rtl/line_fill_ctrl_if.sv
// Bus bundle for line_fill_ctrl: cache-side miss request, memory read port, dictionary lookup
// and line delivery. master = the controller, slave = cache/memory/dictionary side.
interface line_fill_ctrl_if #(
  parameter int unsigned NUM_BLOCKS = 4,
  parameter int unsigned KEY_WIDTH  = 16
);
  logic                             fill_req_valid;
  logic                             fill_req_ready;
  logic [31:0]                      fill_req_addr;

  logic                             mem_req_valid;
  logic                             mem_req_ready;
  logic [31:0]                      mem_req_addr;
  logic [31:0]                      mem_req_rdata;

  logic [31:0]                      dict_val;
  logic                             dict_hit;
  logic [KEY_WIDTH-1:0]             dict_key;

  logic                             crit_valid;
  logic [31:0]                      crit_data;
  logic [31:0]                      fill_line_addr;
  logic                             icache_fill_valid;
  logic [32*NUM_BLOCKS-1:0]         icache_fill_data;
  logic                             comp_fill_valid;
  logic [KEY_WIDTH*NUM_BLOCKS-1:0]  comp_fill_data;

  modport master (
    input  fill_req_valid, fill_req_addr, mem_req_ready, mem_req_rdata, dict_hit, dict_key,
    output fill_req_ready, mem_req_valid, mem_req_addr, dict_val, crit_valid, crit_data,
           fill_line_addr, icache_fill_valid, icache_fill_data, comp_fill_valid, comp_fill_data
  );

  modport slave (
    output fill_req_valid, fill_req_addr, mem_req_ready, mem_req_rdata, dict_hit, dict_key,
    input  fill_req_ready, mem_req_valid, mem_req_addr, dict_val, crit_valid, crit_data,
           fill_line_addr, icache_fill_valid, icache_fill_data, comp_fill_valid, comp_fill_data
  );
endinterface

// File: rtl/line_fill_ctrl.sv
// Instruction cache line fill controller with critical-word-first fill and compressed delivery.
// Optional FILL_STATS_EN adds saturating delivered-line counters (stat_comp_lines/stat_raw_lines).
module line_fill_ctrl #(
  parameter int unsigned NUM_BLOCKS = 4,
  parameter int unsigned KEY_WIDTH  = 16,
  parameter int unsigned WRAP_FILL  = 1
) (
  input  logic              clk,
  input  logic              reset,
  line_fill_ctrl_if.master  bus
`ifdef FILL_STATS_EN
  ,
  output logic [31:0]       stat_comp_lines,
  output logic [31:0]       stat_raw_lines
`endif
);

  localparam int unsigned OffW    = $clog2(NUM_BLOCKS);
  localparam int unsigned LineLsb = OffW + 2;

  typedef enum logic [1:0] {StIdle, StFill, StDeliver} state_e;

  state_e                          state_q, state_d;
  logic [31:0]                     line_q, line_d;
  logic [OffW-1:0]                 cur_word_q, cur_word_d;
  logic [OffW-1:0]                 beat_q, beat_d;
  logic                            comp_q, comp_d;
  logic [32*NUM_BLOCKS-1:0]        data_q, data_d;
  logic [KEY_WIDTH*NUM_BLOCKS-1:0] key_q, key_d;

  logic req_ready, mem_valid, crit_valid, comp_valid, raw_valid;

  // Byte-offset bits of the miss address never matter for a line fill.
  logic unused_addr_bits;
  assign unused_addr_bits = ^bus.fill_req_addr[1:0];

  always_comb begin
    state_d    = state_q;
    line_d     = line_q;
    cur_word_d = cur_word_q;
    beat_d     = beat_q;
    comp_d     = comp_q;
    data_d     = data_q;
    key_d      = key_q;
    req_ready  = 1'b0;
    mem_valid  = 1'b0;
    crit_valid = 1'b0;
    comp_valid = 1'b0;
    raw_valid  = 1'b0;

    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (bus.fill_req_valid) begin
          line_d     = {bus.fill_req_addr[31:LineLsb], {LineLsb{1'b0}}};
          cur_word_d = (WRAP_FILL != 0) ? bus.fill_req_addr[LineLsb-1:2] : '0;
          comp_d     = 1'b1;
          beat_d     = '0;
          state_d    = StFill;
        end
      end
      StFill: begin
        mem_valid = 1'b1;
        if (bus.mem_req_ready) begin
          data_d[32*cur_word_q +: 32]              = bus.mem_req_rdata;
          key_d[KEY_WIDTH*cur_word_q +: KEY_WIDTH] = bus.dict_key;
          comp_d     = comp_q & bus.dict_hit;
          cur_word_d = cur_word_q + 1'b1;
          beat_d     = beat_q + 1'b1;
          crit_valid = (beat_q == '0);
          if (beat_q == OffW'(NUM_BLOCKS - 1)) begin
            state_d = StDeliver;
          end
        end
      end
      StDeliver: begin
        comp_valid = comp_q;
        raw_valid  = ~comp_q;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Reset wins over everything, including outputs of a state not yet cleared by the edge.
    if (reset) begin
      state_d    = StIdle;
      line_d     = '0;
      cur_word_d = '0;
      beat_d     = '0;
      comp_d     = 1'b0;
      data_d     = '0;
      key_d      = '0;
      req_ready  = 1'b0;
      mem_valid  = 1'b0;
      crit_valid = 1'b0;
      comp_valid = 1'b0;
      raw_valid  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    state_q    <= state_d;
    line_q     <= line_d;
    cur_word_q <= cur_word_d;
    beat_q     <= beat_d;
    comp_q     <= comp_d;
    data_q     <= data_d;
    key_q      <= key_d;
  end

  assign bus.fill_req_ready    = req_ready;
  assign bus.mem_req_valid     = mem_valid;
  assign bus.mem_req_addr      = {line_q[31:LineLsb], cur_word_q, 2'b00};
  assign bus.dict_val          = bus.mem_req_rdata;
  assign bus.crit_valid        = crit_valid;
  assign bus.crit_data         = bus.mem_req_rdata;
  assign bus.fill_line_addr    = line_q;
  assign bus.icache_fill_valid = raw_valid;
  assign bus.icache_fill_data  = data_q;
  assign bus.comp_fill_valid   = comp_valid;
  assign bus.comp_fill_data    = key_q;

`ifdef FILL_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_comp_lines <= '0;
      stat_raw_lines  <= '0;
    end else begin
      if (comp_valid && stat_comp_lines != 32'hFFFF_FFFF) begin
        stat_comp_lines <= stat_comp_lines + 32'd1;
      end
      if (raw_valid && stat_raw_lines != 32'hFFFF_FFFF) begin
        stat_raw_lines <= stat_raw_lines + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_line_fill_ctrl.sv
// Directed bench for line_fill_ctrl: one wrap-fill and one linear-fill instance share stimulus.
module tb_line_fill_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        mem_ready;
  logic [31:0] miss_addr;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  line_fill_ctrl_if #(.NUM_BLOCKS(4), .KEY_WIDTH(16)) bus_w ();
  line_fill_ctrl_if #(.NUM_BLOCKS(4), .KEY_WIDTH(16)) bus_l ();

  // Memory word at address a is {16'hDEAD, a[15:0]}; key is the low half of the word.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {16'hDEAD, a[15:0]};
  endfunction

  assign bus_w.fill_req_valid = req_valid;
  assign bus_w.fill_req_addr  = req_addr;
  assign bus_w.mem_req_ready  = mem_ready;
  assign bus_w.mem_req_rdata  = mem_word(bus_w.mem_req_addr);
  assign bus_w.dict_hit       = (bus_w.dict_val != mem_word(miss_addr));
  assign bus_w.dict_key       = bus_w.dict_val[15:0];

  assign bus_l.fill_req_valid = req_valid;
  assign bus_l.fill_req_addr  = req_addr;
  assign bus_l.mem_req_ready  = mem_ready;
  assign bus_l.mem_req_rdata  = mem_word(bus_l.mem_req_addr);
  assign bus_l.dict_hit       = (bus_l.dict_val != mem_word(miss_addr));
  assign bus_l.dict_key       = bus_l.dict_val[15:0];

`ifdef FILL_STATS_EN
  logic [31:0] stat_comp_w, stat_raw_w, stat_comp_l, stat_raw_l;
`endif

  line_fill_ctrl #(.NUM_BLOCKS(4), .KEY_WIDTH(16), .WRAP_FILL(1)) dut_wrap (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_w)
`ifdef FILL_STATS_EN
    ,
    .stat_comp_lines (stat_comp_w),
    .stat_raw_lines  (stat_raw_w)
`endif
  );

  line_fill_ctrl #(.NUM_BLOCKS(4), .KEY_WIDTH(16), .WRAP_FILL(0)) dut_lin (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_l)
`ifdef FILL_STATS_EN
    ,
    .stat_comp_lines (stat_comp_l),
    .stat_raw_lines  (stat_raw_l)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; req_addr = '0; mem_ready = 1'b0; miss_addr = 32'hFFFF_FFFF;
    tick(); tick();
    checks++;
    if ({bus_w.mem_req_valid, bus_w.crit_valid, bus_w.icache_fill_valid, bus_w.comp_fill_valid}
        !== 4'b0000) begin
      errors++;
      $display("FAIL reset_valids: got %b want 0000", {bus_w.mem_req_valid, bus_w.crit_valid,
               bus_w.icache_fill_valid, bus_w.comp_fill_valid});
    end
    checks++;
    if (bus_w.fill_line_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_line_addr: got %h want 0", bus_w.fill_line_addr);
    end
    checks++;
    if (bus_w.icache_fill_data !== 128'h0 || bus_w.comp_fill_data !== 64'h0) begin
      errors++;
      $display("FAIL reset_data: got %h / %h want 0", bus_w.icache_fill_data,
               bus_w.comp_fill_data);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (bus_w.fill_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b want 1", bus_w.fill_req_ready);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_addr [4] = '{32'h1008, 32'h100C, 32'h1000, 32'h1004};
    checks++;
    if (bus_w.fill_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL wrap_ready_c0: got %b want 1", bus_w.fill_req_ready);
    end
    req_valid = 1'b1; req_addr = 32'h0000_1008; mem_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus_w.mem_req_valid !== 1'b1 || bus_w.mem_req_addr !== exp_addr[i]) begin
        errors++;
        $display("FAIL wrap_addr beat%0d: got v=%b %h want v=1 %h", i, bus_w.mem_req_valid,
                 bus_w.mem_req_addr, exp_addr[i]);
      end
      checks++;
      if (bus_w.crit_valid !== (i == 0)) begin
        errors++;
        $display("FAIL wrap_crit_valid beat%0d: got %b want %b", i, bus_w.crit_valid, i == 0);
      end
      if (i == 0) begin
        checks++;
        if (bus_w.crit_data !== 32'hDEAD_1008) begin
          errors++;
          $display("FAIL wrap_crit_data: got %h want DEAD1008", bus_w.crit_data);
        end
        checks++;
        if (bus_w.fill_req_ready !== 1'b0) begin
          errors++;
          $display("FAIL wrap_ready_busy: got %b want 0", bus_w.fill_req_ready);
        end
      end
      tick();
    end
    checks++;
    if (bus_w.comp_fill_valid !== 1'b1 || bus_w.icache_fill_valid !== 1'b0) begin
      errors++;
      $display("FAIL wrap_deliver: got comp=%b raw=%b want comp=1 raw=0",
               bus_w.comp_fill_valid, bus_w.icache_fill_valid);
    end
    checks++;
    if (bus_w.comp_fill_data !== 64'h100C_1008_1004_1000) begin
      errors++;
      $display("FAIL wrap_comp_data: got %h want 100C100810041000", bus_w.comp_fill_data);
    end
    checks++;
    if (bus_w.fill_line_addr !== 32'h1000) begin
      errors++;
      $display("FAIL wrap_line_addr: got %h want 00001000", bus_w.fill_line_addr);
    end
    tick();
    checks++;
    if (bus_w.fill_req_ready !== 1'b1 || bus_w.comp_fill_valid !== 1'b0) begin
      errors++;
      $display("FAIL wrap_c6: got ready=%b comp=%b want ready=1 comp=0",
               bus_w.fill_req_ready, bus_w.comp_fill_valid);
    end
    checks++;
    if (bus_w.comp_fill_data !== 64'h100C_1008_1004_1000) begin
      errors++;
      $display("FAIL wrap_hold: got %h want 100C100810041000", bus_w.comp_fill_data);
    end
  endtask

  task automatic test_linear();
    req_valid = 1'b1; req_addr = 32'h0000_1008; mem_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus_l.mem_req_addr !== 32'h1000 + 32'(4 * i)) begin
        errors++;
        $display("FAIL lin_addr beat%0d: got %h want %h", i, bus_l.mem_req_addr,
                 32'h1000 + 32'(4 * i));
      end
      if (i == 0) begin
        checks++;
        if (bus_l.crit_valid !== 1'b1 || bus_l.crit_data !== 32'hDEAD_1000) begin
          errors++;
          $display("FAIL lin_crit: got v=%b %h want v=1 DEAD1000", bus_l.crit_valid,
                   bus_l.crit_data);
        end
      end
      tick();
    end
    checks++;
    if (bus_l.comp_fill_valid !== 1'b1 || bus_l.comp_fill_data !== 64'h100C_1008_1004_1000)
    begin
      errors++;
      $display("FAIL lin_deliver: got v=%b %h want v=1 100C100810041000",
               bus_l.comp_fill_valid, bus_l.comp_fill_data);
    end
    tick();
  endtask

  task automatic test_raw();
    miss_addr = 32'h1000;
    req_valid = 1'b1; req_addr = 32'h0000_1008; mem_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    tick(); tick(); tick(); tick();
    checks++;
    if (bus_w.icache_fill_valid !== 1'b1 || bus_w.comp_fill_valid !== 1'b0) begin
      errors++;
      $display("FAIL raw_deliver: got raw=%b comp=%b want raw=1 comp=0",
               bus_w.icache_fill_valid, bus_w.comp_fill_valid);
    end
    checks++;
    if (bus_w.icache_fill_data !== 128'hDEAD100C_DEAD1008_DEAD1004_DEAD1000) begin
      errors++;
      $display("FAIL raw_data: got %h want DEAD100CDEAD1008DEAD1004DEAD1000",
               bus_w.icache_fill_data);
    end
    tick();
    checks++;
    if (bus_w.icache_fill_valid !== 1'b0 ||
        bus_w.icache_fill_data !== 128'hDEAD100C_DEAD1008_DEAD1004_DEAD1000) begin
      errors++;
      $display("FAIL raw_hold: got v=%b %h want v=0 DEAD100CDEAD1008DEAD1004DEAD1000",
               bus_w.icache_fill_valid, bus_w.icache_fill_data);
    end
    miss_addr = 32'hFFFF_FFFF;
  endtask

  task automatic test_stall();
    logic [31:0] exp_addr [8] = '{32'h0, 32'h1008, 32'h100C, 32'h100C, 32'h1000, 32'h1000,
                                  32'h1004, 32'h1004};
    req_valid = 1'b1; req_addr = 32'h0000_1008; mem_ready = 1'b0;
    tick();
    req_valid = 1'b0;
    for (int c = 1; c < 8; c++) begin
      mem_ready = c[0];
      #1;
      checks++;
      if (bus_w.mem_req_valid !== 1'b1 || bus_w.mem_req_addr !== exp_addr[c]) begin
        errors++;
        $display("FAIL stall_addr c%0d: got v=%b %h want v=1 %h", c, bus_w.mem_req_valid,
                 bus_w.mem_req_addr, exp_addr[c]);
      end
      checks++;
      if (bus_w.crit_valid !== (c == 1)) begin
        errors++;
        $display("FAIL stall_crit c%0d: got %b want %b", c, bus_w.crit_valid, c == 1);
      end
      tick();
    end
    mem_ready = 1'b0;
    checks++;
    if (bus_w.comp_fill_valid !== 1'b1) begin
      errors++;
      $display("FAIL stall_deliver_c8: got %b want 1", bus_w.comp_fill_valid);
    end
    tick();
    checks++;
    if (bus_w.fill_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_ready_c9: got %b want 1", bus_w.fill_req_ready);
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] exp_addr [4] = '{32'h2004, 32'h2008, 32'h200C, 32'h2000};
    req_valid = 1'b1; req_addr = 32'h0000_1008; mem_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    tick(); tick();
    reset = 1'b1;
    #1;
    checks++;
    if (bus_w.mem_req_valid !== 1'b0 || bus_w.crit_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_in_reset: got mv=%b cv=%b want 0 0", bus_w.mem_req_valid,
               bus_w.crit_valid);
    end
    tick();
    checks++;
    if (bus_w.fill_line_addr !== 32'h0 || bus_w.icache_fill_data !== 128'h0) begin
      errors++;
      $display("FAIL abort_cleared: got %h %h want 0", bus_w.fill_line_addr,
               bus_w.icache_fill_data);
    end
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (bus_w.fill_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_ready: got %b want 1", bus_w.fill_req_ready);
    end
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (bus_w.comp_fill_valid !== 1'b0 || bus_w.icache_fill_valid !== 1'b0) begin
        errors++;
        $display("FAIL abort_no_pulse c%0d: got comp=%b raw=%b want 0 0", c,
                 bus_w.comp_fill_valid, bus_w.icache_fill_valid);
      end
      tick();
    end
    req_valid = 1'b1; req_addr = 32'h0000_2004;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus_w.mem_req_addr !== exp_addr[i]) begin
        errors++;
        $display("FAIL refill_addr beat%0d: got %h want %h", i, bus_w.mem_req_addr,
                 exp_addr[i]);
      end
      if (i == 0) begin
        checks++;
        if (bus_w.crit_data !== 32'hDEAD_2004) begin
          errors++;
          $display("FAIL refill_crit: got %h want DEAD2004", bus_w.crit_data);
        end
      end
      tick();
    end
    checks++;
    if (bus_w.comp_fill_valid !== 1'b1 || bus_w.comp_fill_data !== 64'h200C_2008_2004_2000 ||
        bus_w.fill_line_addr !== 32'h2000) begin
      errors++;
      $display("FAIL refill_deliver: got v=%b %h %h want v=1 200C200820042000 00002000",
               bus_w.comp_fill_valid, bus_w.comp_fill_data, bus_w.fill_line_addr);
    end
    tick();
  endtask

`ifdef FILL_STATS_EN
  task automatic run_fill(input logic [31:0] addr);
    req_valid = 1'b1; req_addr = addr; mem_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
  endtask

  task automatic test_stats();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    checks++;
    if (stat_comp_w !== 32'd0 || stat_raw_w !== 32'd0) begin
      errors++;
      $display("FAIL stats_reset: got %0d %0d want 0 0", stat_comp_w, stat_raw_w);
    end
    miss_addr = 32'hFFFF_FFFF;
    run_fill(32'h1008); run_fill(32'h3000); run_fill(32'h400C);
    miss_addr = 32'h1000;
    run_fill(32'h1008); run_fill(32'h100C);
    miss_addr = 32'hFFFF_FFFF;
    checks++;
    if (stat_comp_w !== 32'd3 || stat_raw_w !== 32'd2) begin
      errors++;
      $display("FAIL stats_counts: got comp=%0d raw=%0d want 3 2", stat_comp_w, stat_raw_w);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_wrap();
    test_linear();
    test_raw();
    test_stall();
    test_reset_abort();
`ifdef FILL_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
